sw_debouncer: RTL
=================

// Module: sw_debouncer
// PURPOSE
//  Upstream conditioning stage for the slide-switch bus feeding the muxer/decoder
//  datapath: synchronises raw SW[9:0] to clk, debounces every bit independently, and
//  drives a stable bus (sw_db) to the combinational mux/7-seg stage.
//  Per-bit rise/fall strobes and an any-change strobe let downstream logic react
//  once per real switch flip.
// PARAMETERS
//  WIDTH          10       number of switch bits
//  STABLE_CYCLES  500000   consecutive cycles a new level must persist (10 ms @ 50 MHz); legal >= 1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  sw_raw     in   WIDTH  raw switch levels, asynchronous to clk
//  sw_db      out  WIDTH  debounced switch levels (to muxer SW input)
//  sw_rise    out  WIDTH  1-cycle strobe per bit, debounced 0->1
//  sw_fall    out  WIDTH  1-cycle strobe per bit, debounced 1->0
//  sw_changed out  1      1-cycle strobe = |(sw_rise | sw_fall)
// BEHAVIOUR
//  - Reset (rst_n low, async assert; deassert handled by external reset synchroniser):
//    sync flops, sw_db, sw_rise, sw_fall, sw_changed, all counters = 0.
//  - Sync: two flops per bit (s1 <= sw_raw, s2 <= s1); only s2 is used downstream.
//  - Per bit i, counter cnt[i], width max(1,$clog2(STABLE_CYCLES)):
//    * s2 == sw_db[i]                        : cnt <= 0, no update.
//    * s2 != sw_db[i], cnt != STABLE_CYCLES-1 : cnt <= cnt+1.
//    * s2 != sw_db[i], cnt == STABLE_CYCLES-1 : sw_db[i] <= s2, cnt <= 0, strobe.
//  - Bounce: any cycle with s2 == sw_db[i] clears cnt; count restarts from 0.
//  - Latency: sw_raw change first sampled at edge 1 -> sw_db updates at edge STABLE_CYCLES+2.
//  - Strobes: registered, asserted exactly the cycle sw_db shows the new value; high
//    for one cycle. sw_rise[i] iff new value 1, sw_fall[i] iff 0; never both on one bit.
//  - Multiple bits qualifying on the same edge: all update together; sw_changed one pulse.
//  - Bits fully independent; no cross-bit interaction except the sw_changed OR.
//  - Switch already high at reset release: sw_db rises STABLE_CYCLES+2 edges later
//    with a sw_rise strobe (no special power-up path).
//  - Reset mid-count: counters, sw_db and strobes return to 0 immediately; any partial
//    qualification is discarded.
//  - Counter never exceeds STABLE_CYCLES-1; no wrap possible.
// STRUCTURE
//  - Package sw_debounce_pkg: SW_WIDTH=10, DEFAULT_STABLE_CYCLES=500000,
//    SIM_STABLE_CYCLES=4, localparam function for counter width.
//  - Sub-module sw_debounce_bit (sync pair, counter, stable flop, rise/fall flops),
//    instantiated WIDTH times via generate; top adds the sw_changed OR-reduce flop.
// TESTING (STABLE_CYCLES=4)
//  - Reset: rst_n=0 with sw_raw=10'h3FF -> all outputs 0; release -> sw_db=10'h3FF at
//    edge 6, sw_rise=10'h3FF and sw_changed=1 for exactly that cycle.
//  - Clean flip: sw_raw[0] 0->1 held -> sw_db[0]=1 at edge 6, sw_rise[0] 1-cycle, others 0.
//  - Bounce: sw_raw[3] toggles 1,0,1,0 each cycle then holds 1 -> no sw_db change until 6
//    edges after the final transition; exactly one sw_rise[3].
//  - Glitch: sw_raw[5] high for 3 cycles then low -> sw_db[5] stays 0, no strobes.
//  - Simultaneous: sw_raw[9:8] 00->11 and sw_raw[0] 1->0 same edge -> one cycle with
//    sw_rise=10'h300, sw_fall=10'h001, sw_changed=1 (single pulse).
//  - Reset mid-count: sw_raw[2] rises, assert rst_n at edge 4 -> sw_db=0, counters cleared;
//    after release sw_db[2] rises at edge 6 counted from release.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Holds the bus width, the qualification lengths and the counter sizing.
package sw_debounce_pkg;

  localparam int SW_WIDTH              = 10;
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int SIM_STABLE_CYCLES     = 4;

  // Per-bit decision taken on each clock edge.
  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_COMMIT = 2'd2
  } db_action_e;

  // The counter must hold 0 .. stable_cycles-1 and is never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch bit: two-flop synchroniser, stability counter,
// debounced level flop and registered rise/fall strobes.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw_raw,
  output logic o_sw_db,
  output logic o_sw_rise,
  output logic o_sw_fall,
  output logic o_commit
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  db_action_e    w_act;

  // Any sample matching the current level discards the partial count.
  always_comb begin
    w_act = ACT_CLEAR;
    if (r_s2 != r_db) begin
      if (r_cnt == CNT_LAST) w_act = ACT_COMMIT;
      else                   w_act = ACT_COUNT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_sw_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (w_act)
        ACT_COUNT: r_cnt <= r_cnt + CNT_ONE;
        ACT_COMMIT: begin
          r_cnt  <= '0;
          r_db   <= r_s2;
          r_rise <= r_s2;
          r_fall <= ~r_s2;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_sw_db   = r_db;
  assign o_sw_rise = r_rise;
  assign o_sw_fall = r_fall;
  assign o_commit  = (w_act == ACT_COMMIT);

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch conditioning stage: per-bit independent debouncers plus a
// registered any-change strobe aligned with the per-bit rise/fall strobes.
module sw_debouncer
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_sw_db,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_sw_changed
);

  logic [WIDTH-1:0] w_commit;
  logic             r_changed;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bit (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_sw_raw  (i_sw_raw[gi]),
      .o_sw_db   (o_sw_db[gi]),
      .o_sw_rise (o_sw_rise[gi]),
      .o_sw_fall (o_sw_fall[gi]),
      .o_commit  (w_commit[gi])
    );
  end

  // Built from the pre-register commits so the pulse lands with the bit strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_changed <= 1'b0;
    else          r_changed <= |w_commit;
  end

  assign o_sw_changed = r_changed;

endmodule
